// File: rtl/instr_mem_loader.sv
// Runtime-loadable instruction memory: a byte-stream loader writes program words,
// NOP-fills the rest, then releases the core through cpu_run; fetch is registered.
module instr_mem_loader #(
  parameter int DATA_W = 16,
  parameter int LOAD_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [LOAD_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              cpu_run,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);
  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE_L   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_L  = DEPTH_L - ONE_L;

  typedef enum logic [2:0] {IDLE, LOAD_HI, LOAD_LO, FILL, FINISH} state_e;

  state_e              state_q, state_d;
  logic                loaded_q, loaded_d;
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [LOAD_W-1:0]   hi_q, hi_d;
  logic [ADDR_W:0]     len_clamp;
  logic [ADDR_W:0]     ptr_inc;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign len_clamp  = (load_len > DEPTH_L) ? DEPTH_L : load_len;
  assign ptr_inc    = wr_ptr_q + ONE_L;
  assign cpu_run    = loaded_q && (state_q == IDLE);
  assign load_count = count_q;
  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;

  always_comb begin
    state_d    = state_q;
    loaded_d   = loaded_q;
    wr_ptr_d   = wr_ptr_q;
    len_d      = len_q;
    count_d    = count_q;
    hi_d       = hi_q;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    load_ready = 1'b0;
    load_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          len_d    = len_clamp;
          wr_ptr_d = '0;
          count_d  = '0;
          loaded_d = 1'b0;
          state_d  = (len_clamp == '0) ? FILL : LOAD_HI;
        end
      end
      LOAD_HI: begin
        load_ready = 1'b1;
        if (load_valid) begin
          hi_d    = load_data;
          state_d = LOAD_LO;
        end
      end
      LOAD_LO: begin
        load_ready = 1'b1;
        if (load_valid) begin
          mem_we    = 1'b1;
          mem_wdata = {hi_q, load_data};
          wr_ptr_d  = ptr_inc;
          count_d   = count_q + ONE_L;
          // A full-depth image has nothing left to fill.
          if (ptr_inc == len_q) state_d = (len_q == DEPTH_L) ? FINISH : FILL;
          else                  state_d = LOAD_HI;
        end
      end
      FILL: begin
        mem_we   = 1'b1;
        wr_ptr_d = ptr_inc;
        if (wr_ptr_q == LAST_L) state_d = FINISH;
      end
      FINISH: begin
        load_done = 1'b1;
        loaded_d  = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      loaded_q <= 1'b0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Datapath: no reset, contents are meaningless until a load completes.
  always_ff @(posedge clk) begin
    len_q <= len_d;
    hi_q  <= hi_d;
    if (mem_we) mem[wr_ptr_q[ADDR_W-1:0]] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (cpu_run && fetch_en) begin
      rdata_q  <= mem[addr];
      rvalid_q <= 1'b1;
    end else if (cpu_run) begin
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: a reference image built from the byte
// stream predicts fetch data; a monitor pops expectations whenever rvalid is seen.
module tb_instr_mem_loader;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [8:0]  load_len;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        load_done;
  logic [8:0]  load_count;
  logic        cpu_run;
  logic        fetch_en;
  logic [7:0]  addr;
  logic [15:0] rdata;
  logic        rvalid;

  instr_mem_loader #(.DATA_W(16), .LOAD_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done), .load_count(load_count), .cpu_run(cpu_run),
    .fetch_en(fetch_en), .addr(addr), .rdata(rdata), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_mem [DEPTH];
  bit          model_run = 0;
  logic [7:0]  prog [512];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented fetch result is matched against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rvalid === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_rvalid", 32'(rdata), 32'hFFFF_FFFF);
        else chk("fetch_data", 32'(rdata), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic fetch(input logic [7:0] a);
    fetch_en = 1'b1;
    addr     = a;
    if (model_run) exp_q.push_back(model_mem[a]);
    tick();
    if (!model_run) chk("nop_fetch", {15'd0, rvalid, rdata}, 32'd0);
  endtask

  // mode: 0 continuous valid, 1 valid toggling (low on the first loader cycle), 2 random.
  task automatic run_load(input int len, input int mode, input bit rs_fetch,
                          input logic [7:0] rs_addr, input bit ign);
    int lenc, nb, k, e, n, last_e;
    bit v;
    lenc = (len > DEPTH) ? DEPTH : len;
    nb   = 2 * lenc;
    load_start = 1'b1;
    load_len   = 9'(len);
    load_valid = 1'b1;
    load_data  = 8'hA5;
    if (rs_fetch) begin
      fetch_en = 1'b1;
      addr     = rs_addr;
      if (model_run) exp_q.push_back(model_mem[rs_addr]);
    end else begin
      fetch_en = 1'b0;
    end
    tick();
    model_run  = 0;
    load_start = 1'b0;
    load_len   = 9'd0;
    chk("run_drop", {31'd0, cpu_run}, 32'd0);
    e = 0;
    k = 0;
    while (k < nb) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = ((e + 1) % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      load_valid = v;
      load_data  = prog[k];
      load_start = ign && (k == 3);
      fetch_en   = 1'b1;
      addr       = 8'($urandom);
      chk("ready", {31'd0, load_ready}, 32'd1);
      tick();
      e++;
      if (v) k++;
      chk("load_nop", {15'd0, rvalid, rdata}, 32'd0);
    end
    last_e     = e;
    load_valid = 1'b0;
    load_start = 1'b0;
    n = 0;
    while (load_done !== 1'b1 && n < 1200) begin
      addr = 8'($urandom);
      tick();
      e++;
      n++;
      chk("load_nop", {15'd0, rvalid, rdata}, 32'd0);
    end
    if (load_done !== 1'b1) begin
      chk("done_timeout", {31'd0, load_done}, 32'd1);
      return;
    end
    chk("done_edge", 32'(e), 32'(last_e + DEPTH - lenc));
    chk("load_count", 32'(load_count), 32'(lenc));
    fetch_en = 1'b0;
    tick();
    chk("done_pulse", {31'd0, load_done}, 32'd0);
    chk("cpu_run", {31'd0, cpu_run}, 32'd1);
    for (int i = 0; i < DEPTH; i++)
      model_mem[i] = (i < lenc) ? {prog[2*i], prog[2*i+1]} : 16'h0000;
    model_run = 1;
  endtask

  task automatic rand_prog();
    for (int i = 0; i < 512; i++) prog[i] = 8'($urandom);
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; load_len = '0; load_valid = 1'b0;
    load_data = '0; fetch_en = 1'b1; addr = 8'd0;

    // Reset
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_outs", {23'd0, cpu_run, load_ready, load_done, load_count, rvalid},
        32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    fetch(8'd0);

    // Short load with continuous valid
    prog[0] = 8'h49; prog[1] = 8'h05; prog[2] = 8'hD0;
    prog[3] = 8'h07; prog[4] = 8'h08; prog[5] = 8'h00;
    run_load(3, 0, 0, 8'd0, 0);
    chk("short_w1", 32'(model_mem[1]), 32'h0000_D007);
    fetch(8'd0); fetch(8'd1); fetch(8'd2); fetch(8'd3); fetch(8'd255);

    // Stall holds rdata
    fetch(8'd1);
    fetch_en = 1'b0;
    repeat (3) begin
      tick();
      chk("stall_hold", {15'd0, rvalid, rdata}, {16'd0, 16'hD007});
    end

    // Backpressure: same image, done six cycles later
    run_load(3, 1, 0, 8'd0, 0);
    for (int a = 0; a < 4; a++) fetch(8'(a));
    fetch(8'd255);

    // Restart while fetching, with an ignored second start in LOAD_LO
    rand_prog();
    run_load(20, 0, 1, 8'd1, 1);
    repeat (10) fetch(8'($urandom_range(0, 25)));

    // Empty image: memory entirely NOP
    run_load(0, 0, 1, 8'd2, 0);
    repeat (8) fetch(8'($urandom));

    // Reset mid-load
    fetch_en   = 1'b0;
    load_start = 1'b1; load_len = 9'd256; load_valid = 1'b1; load_data = 8'h3C;
    tick();
    model_run  = 0;
    load_start = 1'b0;
    repeat (4) tick();
    chk("mid_count", 32'(load_count), 32'd2);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    load_valid = 1'b0;
    chk("mid_rst", {29'd0, cpu_run, load_ready, load_done}, 32'd0);
    chk("mid_rst_cnt", 32'(load_count), 32'd0);
    repeat (3) fetch(8'($urandom));

    // Full-depth load, then an oversize length that must clamp
    rand_prog();
    run_load(256, 0, 0, 8'd0, 0);
    fetch(8'd255); fetch(8'd0); fetch(8'($urandom));
    run_load(300, 0, 0, 8'd0, 0);
    fetch(8'd255); fetch(8'd128);

    // Random images with random valid gaps
    for (int r = 0; r < 4; r++) begin
      rand_prog();
      run_load(int'($urandom_range(1, 60)), 2, 1'($urandom_range(0, 1)),
               8'($urandom), 0);
      repeat (16) fetch(8'($urandom_range(0, 70)));
    end

    fetch_en = 1'b0;
    repeat (2) tick();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
